// File: rtl/rle_decoder.sv
// rle_decoder: rebuilds an 8x8 block of N-bit coefficients from a DC/AC
// run-length symbol stream. Coefficients are placed in JPEG zigzag order.
// Output element rle_out[r][7-c] holds row r, column c.
//
// Handshake: a symbol transfers on a rising clk edge when in_valid && in_ready.
// in_ready depends only on FSM state and stall, never on in_valid.
// out_valid stays high while the finished block sits in DONE, and stall holds it there.
module rle_decoder #(
  parameter int N = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     in_valid,
  input  logic                     in_dc,
  input  logic                     in_last,
  input  logic [N+3:0]             in_data,
  output logic                     in_ready,
  output logic [7:0][7:0][N-1:0]   rle_out,
  output logic                     out_valid,
  output logic                     err,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    S_CLEAR   = 2'd0,
    S_WAIT_DC = 2'd1,
    S_AC      = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Zigzag scan position -> linear index (row*8 + col).
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  state_t                   r_state;
  logic [6:0]               r_pos;
  logic                     r_err;
  logic [7:0][7:0][N-1:0]   r_blk;

  state_t                   w_state_nxt;
  logic [6:0]               w_pos_nxt;
  logic                     w_err_nxt;
  logic                     w_clear;
  logic                     w_wr_en;
  logic [2:0]               w_wr_row;
  logic [2:0]               w_wr_col;
  logic                     w_accept;
  logic [6:0]               w_run;
  logic [N-1:0]             w_level;
  logic [6:0]               w_target;
  logic [5:0]               w_zz;

  assign in_ready  = ((r_state == S_WAIT_DC) || (r_state == S_AC)) && !stall;
  assign w_accept  = in_valid && in_ready;
  assign w_run     = {3'b000, in_data[N+3:N]};
  assign w_level   = in_data[N-1:0];
  // Target is computed at 7 bits so an overflow past 63 is visible, not wrapped.
  assign w_target  = r_pos + w_run;
  assign w_zz      = ZZ[w_target[5:0]];

  assign rle_out   = r_blk;
  assign out_valid = (r_state == S_DONE);
  assign err       = r_err;
  assign dbg_state = r_state;

  // State, scan position and error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_pos   <= 7'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state logic plus the coefficient write request for the accepted symbol.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_err_nxt   = r_err;
    w_clear     = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_row    = 3'd0;
    w_wr_col    = 3'd0;
    case (r_state)
      S_CLEAR: begin
        w_clear     = 1'b1;
        w_err_nxt   = 1'b0;
        w_pos_nxt   = 7'd0;
        w_state_nxt = S_WAIT_DC;
      end
      S_WAIT_DC: begin
        if (w_accept) begin
          if (in_dc) begin
            w_wr_en   = 1'b1;
            w_pos_nxt = 7'd1;
            if (in_last) begin
              // A block cannot end on its DC word.
              w_err_nxt   = 1'b1;
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_AC;
            end
          end else begin
            // Stray AC symbol before the DC word: drop it and remember the error.
            w_err_nxt = 1'b1;
          end
        end
      end
      S_AC: begin
        if (w_accept) begin
          if (in_dc) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else if (w_target > 7'd63) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_wr_en   = 1'b1;
            w_wr_row  = w_zz[5:3];
            w_wr_col  = w_zz[2:0];
            w_pos_nxt = w_target + 7'd1;
            if (in_last || (w_target == 7'd63)) begin
              w_state_nxt = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        if (!stall) begin
          w_state_nxt = S_CLEAR;
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
      end
    endcase
  end

  // Coefficient store: wiped in CLEAR, one write per accepted symbol.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blk <= '0;
    end else if (w_clear) begin
      r_blk <= '0;
    end else if (w_wr_en) begin
      r_blk[w_wr_row][3'd7 - w_wr_col] <= w_level;
    end
  end

endmodule

// File: tb/tb_rle_decoder.sv
// Directed testbench for rle_decoder with hand-computed expected blocks.
module tb_rle_decoder;

  localparam int N  = 12;
  localparam int CW = 64 * N;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    stall;
  logic                    in_valid;
  logic                    in_dc;
  logic                    in_last;
  logic [N+3:0]            in_data;
  logic                    in_ready;
  logic [7:0][7:0][N-1:0]  rle_out;
  logic                    out_valid;
  logic                    err;
  logic [1:0]              dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0][7:0][N-1:0]  exp_blk;
  logic [CW-1:0]           exp_q[$];

  rle_decoder #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .in_valid  (in_valid),
    .in_dc     (in_dc),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .rle_out   (rle_out),
    .out_valid (out_valid),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_clear();
    exp_blk = '0;
  endtask

  task automatic exp_put(input int r, input int c, input logic [N-1:0] v);
    exp_blk[r][7-c] = v;
  endtask

  task automatic exp_push();
    exp_q.push_back(exp_blk);
  endtask

  // Drive one symbol and hold it until it is accepted on a rising edge.
  task automatic send(input bit dc, input bit last, input int run, input logic [N-1:0] lvl);
    int waited;
    logic [3:0] r4;
    r4 = run[3:0];
    @(negedge clk);
    in_valid = 1'b1;
    in_dc    = dc;
    in_last  = last;
    in_data  = {r4, lvl};
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("send_timeout", in_ready, 1);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_dc    = 1'b0;
    in_last  = 1'b0;
  endtask

  // Expect the block to be presented for exactly one cycle.
  task automatic finish_block(input string tag, input bit exp_err);
    logic [CW-1:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    @(negedge clk);
    check({tag, "_ov"},   out_valid, 1);
    check({tag, "_err"},  err, exp_err);
    check({tag, "_blk"},  rle_out, e);
    check({tag, "_rdy"},  in_ready, 0);
    @(negedge clk);
    check({tag, "_ovfall"}, out_valid, 0);
    check({tag, "_clrrdy"}, in_ready, 0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; in_valid = 1'b0; in_dc = 1'b0; in_last = 1'b0; in_data = '0;
    #12;
    check("rst_ov",    out_valid, 0);
    check("rst_err",   err, 0);
    check("rst_rdy",   in_ready, 0);
    check("rst_blk",   rle_out, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic block.
    exp_clear(); exp_put(0,0,12'h005); exp_put(0,1,12'h003); exp_put(1,1,12'hFFE); exp_push();
    send(1, 0, 0, 12'h005);
    send(0, 0, 0, 12'h003);
    send(0, 0, 2, 12'hFFE);
    send(0, 1, 0, 12'h000);
    finish_block("basic", 0);

    // Full length through ZRLs, ending with last.
    exp_clear(); exp_put(0,0,12'h001); exp_put(7,7,12'h7FF); exp_push();
    send(1, 0, 0, 12'h001);
    for (int i = 0; i < 3; i++) send(0, 0, 15, 12'h000);
    send(0, 1, 14, 12'h7FF);
    finish_block("zrl_last", 0);

    // Same, ending at position 63 without last.
    exp_push();
    send(1, 0, 0, 12'h001);
    for (int i = 0; i < 3; i++) send(0, 0, 15, 12'h000);
    send(0, 0, 14, 12'h7FF);
    finish_block("zrl_63", 0);

    // Stall mid-stream and during DONE.
    exp_clear(); exp_put(0,0,12'h005); exp_put(0,1,12'h003); exp_put(1,1,12'hFFE);
    send(1, 0, 0, 12'h005);
    send(0, 0, 0, 12'h003);
    @(negedge clk);
    stall = 1'b1; in_valid = 1'b1; in_dc = 1'b0; in_last = 1'b0; in_data = {4'd2, 12'hFFE};
    #1;
    check("stall_rdy", in_ready, 0);
    @(negedge clk);
    stall = 1'b0; in_valid = 1'b0;
    send(0, 0, 2, 12'hFFE);
    send(0, 1, 0, 12'h000);
    @(negedge clk);
    stall = 1'b1;
    check("stall_done_ov0", out_valid, 1);
    check("stall_done_blk", rle_out, exp_blk);
    check("stall_done_err", err, 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("stall_done_ov%0d", i), out_valid, 1);
      check($sformatf("stall_done_rdy%0d", i), in_ready, 0);
    end
    stall = 1'b0;
    @(negedge clk);
    check("stall_done_ovfall", out_valid, 0);

    // Overflow: fourth ZRL targets position 64.
    exp_clear(); exp_put(0,0,12'h010); exp_push();
    send(1, 0, 0, 12'h010);
    for (int i = 0; i < 4; i++) send(0, 0, 15, 12'h000);
    finish_block("ovf", 1);

    // Stray AC symbol before DC.
    exp_clear(); exp_put(0,0,12'h002); exp_push();
    send(0, 0, 0, 12'h055);
    send(1, 0, 0, 12'h002);
    send(0, 1, 0, 12'h000);
    finish_block("stray_ac", 1);

    // DC word in the middle of the AC run.
    exp_clear(); exp_put(0,0,12'h007); exp_put(0,1,12'h004); exp_push();
    send(1, 0, 0, 12'h007);
    send(0, 0, 0, 12'h004);
    send(1, 0, 0, 12'h009);
    finish_block("dc_mid", 1);

    // Back-to-back: block A puts 0x123 at (3,4), block B must be all zero.
    exp_clear(); exp_put(3,4,12'h123); exp_push();
    send(1, 0, 0, 12'h000);
    send(0, 0, 15, 12'h000);
    send(0, 1, 14, 12'h123);
    finish_block("blk_a", 0);
    exp_clear(); exp_push();
    send(1, 0, 0, 12'h000);
    send(0, 1, 0, 12'h000);
    finish_block("blk_b", 0);

    // Asynchronous reset mid-block, then a clean block.
    send(1, 0, 0, 12'h3AB);
    send(0, 0, 0, 12'h111);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_blk",   rle_out, 0);
    check("arst_rdy",   in_ready, 0);
    check("arst_ov",    out_valid, 0);
    check("arst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_clear(); exp_put(0,0,12'h004); exp_put(1,0,12'h00F); exp_push();
    send(1, 0, 0, 12'h004);
    send(0, 1, 1, 12'h00F);
    finish_block("post_rst", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog in case the flow above stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
